// File: rtl/us_sched_pkg.sv
// us_sched_pkg
//   Shared types and defaults for the ultrasonic scan scheduler.
//   - state_t       : scheduler FSM state encoding
//   - GUARD_CYC_DEF : default idle cycles between shots (60 ms at 50 MHz)
//   - TO_CYC_DEF    : default per-shot timeout (30 ms at 50 MHz)
//   - max_int       : helper used to size the shared cycle timer
package us_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_FIRE,
    ST_WAIT,
    ST_CAPTURE,
    ST_GUARD
  } state_t;

  localparam int GUARD_CYC_DEF = 3000000;
  localparam int TO_CYC_DEF    = 1500000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/us_cyc_timer.sv
// us_cyc_timer
//   Loadable down-counter with a zero flag. Load has priority over
//   decrement; the count saturates at zero.
// Ports:
//   clk      : system clock (rising edge)
//   rst      : asynchronous active-low reset (count cleared)
//   load     : load load_val on the next edge
//   load_val : value to load
//   en       : decrement by one when not loading
//   zero     : count is zero
module us_cyc_timer #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/us_scan_sched.sv
// us_scan_sched
//   Round-robin scheduler for N_CH ultrasonic ranging channels. Fires one
//   channel at a time, waits for its done pulse, captures its distance,
//   then idles GUARD_CYC cycles before the next shot.
//   Optional macro US_SCHED_TIMEOUT_EN: a shot with no done within TO_CYC
//   WAIT cycles is captured as all-ones with err pulsed. Without it, WAIT
//   is left only on done and err is constant 0.
// Ports:
//   clk        : system clock (rising edge)
//   rst        : asynchronous active-low reset
//   run        : keep scheduling shots while high
//   ch_en      : per-channel enable mask
//   done       : per-channel completion pulses
//   dist_in    : packed distances, channel k at [k*CNT_W +: CNT_W]
//   start      : one-hot one-cycle start pulse
//   dist_out   : distance of the last finished shot
//   dist_ch    : channel index of dist_out
//   dist_vld   : one-cycle pulse when dist_out/dist_ch update
//   err        : one-cycle pulse with dist_vld on a timed-out shot
//   frame_done : pulse with dist_vld for the last enabled channel of a round
//   busy       : high whenever not IDLE
module us_scan_sched
  import us_sched_pkg::*;
#(
  parameter  int N_CH      = 4,
  parameter  int CNT_W     = 16,
  parameter  int GUARD_CYC = GUARD_CYC_DEF,
  parameter  int TO_CYC    = TO_CYC_DEF,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       done,
  input  logic [N_CH*CNT_W-1:0] dist_in,
  output logic [N_CH-1:0]       start,
  output logic [CNT_W-1:0]      dist_out,
  output logic [CH_W-1:0]       dist_ch,
  output logic                  dist_vld,
  output logic                  err,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int TMR_W = $clog2(max_int(GUARD_CYC, TO_CYC) + 1);

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   ch_reg, ch_next;        // current / previous channel
  logic              last_reg, last_next;    // ch_reg is top bit of sampled mask
  logic [N_CH-1:0]   start_reg, start_next;
  logic [CNT_W-1:0]  dist_out_reg, dist_out_next;
  logic [CH_W-1:0]   dist_ch_reg, dist_ch_next;
  logic              dist_vld_reg, dist_vld_next;
  logic              frame_done_reg, frame_done_next;

  logic              tmr_load, tmr_en, tmr_zero;
  logic [TMR_W-1:0]  tmr_val;

  logic [CNT_W-1:0]  dist_arr [N_CH];

  logic [CH_W-1:0]   sel_ch, top_ch;
  logic              sel_found;
  int                sel_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_slice
      assign dist_arr[gi] = dist_in[gi*CNT_W +: CNT_W];
    end
  endgenerate

  us_cyc_timer #(
    .W (TMR_W)
  ) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // Round-robin search: first enabled channel strictly after ch_reg, with
  // wrap (ch_reg itself is considered last). Also find the highest enabled
  // channel so the end of a round can be flagged.
  always_comb begin
    sel_ch    = ch_reg;
    sel_found = 1'b0;
    top_ch    = '0;
    sel_idx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_en[CH_W'(i)]) top_ch = CH_W'(i);
    end
    for (int i = 1; i <= N_CH; i++) begin
      sel_idx = int'(ch_reg) + i;
      if (sel_idx >= N_CH) sel_idx = sel_idx - N_CH;
      if (!sel_found && ch_en[CH_W'(sel_idx)]) begin
        sel_ch    = CH_W'(sel_idx);
        sel_found = 1'b1;
      end
    end
  end

`ifdef US_SCHED_TIMEOUT_EN
  logic err_reg, err_next;
`endif

  always_comb begin
    state_next      = state_reg;
    ch_next         = ch_reg;
    last_next       = last_reg;
    start_next      = '0;
    dist_out_next   = dist_out_reg;
    dist_ch_next    = dist_ch_reg;
    dist_vld_next   = 1'b0;
    frame_done_next = 1'b0;
    tmr_load        = 1'b0;
    tmr_en          = 1'b0;
    tmr_val         = '0;
`ifdef US_SCHED_TIMEOUT_EN
    err_next        = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (run && (ch_en != '0)) state_next = ST_SELECT;
      end
      ST_SELECT: begin
        if (!sel_found) begin
          state_next = ST_IDLE;
        end else begin
          ch_next            = sel_ch;
          last_next          = (sel_ch == top_ch);
          start_next[sel_ch] = 1'b1;   // registered: visible in FIRE
          state_next         = ST_FIRE;
        end
      end
      ST_FIRE: begin
        // Timer reloads here so WAIT cycle n sees TO_CYC-n; a done during
        // this cycle is deliberately not looked at.
        tmr_load   = 1'b1;
        tmr_val    = TMR_W'(TO_CYC - 1);
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_en = 1'b1;
        // Distance is sampled on the same edge as done; outputs update
        // as the FSM enters CAPTURE so dist_vld is high during CAPTURE.
        if (done[ch_reg]) begin
          dist_out_next   = dist_arr[ch_reg];
          dist_ch_next    = ch_reg;
          dist_vld_next   = 1'b1;
          frame_done_next = last_reg;
          state_next      = ST_CAPTURE;
        end
`ifdef US_SCHED_TIMEOUT_EN
        else if (tmr_zero) begin
          dist_out_next   = '1;
          dist_ch_next    = ch_reg;
          dist_vld_next   = 1'b1;
          frame_done_next = last_reg;
          err_next        = 1'b1;
          state_next      = ST_CAPTURE;
        end
`endif
      end
      ST_CAPTURE: begin
        tmr_load   = 1'b1;
        tmr_val    = TMR_W'(GUARD_CYC - 1);
        state_next = ST_GUARD;
      end
      ST_GUARD: begin
        tmr_en = 1'b1;
        if (tmr_zero) state_next = run ? ST_SELECT : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      ch_reg         <= CH_W'(N_CH - 1);   // first search lands on channel 0
      last_reg       <= 1'b0;
      start_reg      <= '0;
      dist_out_reg   <= '0;
      dist_ch_reg    <= '0;
      dist_vld_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ch_reg         <= ch_next;
      last_reg       <= last_next;
      start_reg      <= start_next;
      dist_out_reg   <= dist_out_next;
      dist_ch_reg    <= dist_ch_next;
      dist_vld_reg   <= dist_vld_next;
      frame_done_reg <= frame_done_next;
    end
  end

`ifdef US_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_reg <= 1'b0;
    else      err_reg <= err_next;
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign start      = start_reg;
  assign dist_out   = dist_out_reg;
  assign dist_ch    = dist_ch_reg;
  assign dist_vld   = dist_vld_reg;
  assign frame_done = frame_done_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule
